// File: rtl/alu_sequencer_if.sv
// Command/result handshake bundle between a command source and alu_sequencer.
// The master drives commands and consumes results; the slave is the sequencer.
interface alu_sequencer_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned FUNCT_W = 4;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [FUNCT_W-1:0]   cmd_funct;
  logic                 cmd_use_acc;
  logic [DATA_W-1:0]    cmd_a;
  logic [DATA_W-1:0]    cmd_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [DATA_W-1:0]    res_data;
  logic                 res_carry;
  logic                 res_overflow;
  logic                 res_err;

  modport master (
    output cmd_valid, cmd_funct, cmd_use_acc, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_carry, res_overflow, res_err
  );

  modport slave (
    input  cmd_valid, cmd_funct, cmd_use_acc, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_carry, res_overflow, res_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Control stage for the 8-bit ALU: owns the ALU state register, operand registers,
// accumulator and result buffer. Optional perf counters under ALU_SEQ_PERF_EN.
module alu_sequencer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PERF_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_sequencer_if.slave        bus,
  input  logic                  err_clr,
  output logic [3:0]            alu_funct,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [1:0]            alu_state,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic                  alu_carry,
  input  logic                  alu_overflow,
  output logic [DATA_W-1:0]     acc_value
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_ops,
  output logic [PERF_CNT_W-1:0] perf_errs
`endif
);

  localparam int unsigned FUNCT_W = 4;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_READY = 2'd0,
    ST_ARITH = 2'd1,
    ST_LOGIC = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [FUNCT_W-1:0]  funct_q, funct_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_carry_q, res_carry_d;
  logic                res_ovf_q, res_ovf_d;
  logic                res_err_q, res_err_d;

  logic                drain_c, cmd_ready_c, accept_c;
  logic                carry_sel_c, ovf_sel_c, fault_c;

  // A result slot is free when empty or being consumed this cycle
  assign drain_c     = !res_valid_q || bus.res_ready;
  assign cmd_ready_c = (state_q == ST_READY) && drain_c && rst_n;
  assign accept_c    = bus.cmd_valid && cmd_ready_c;

  // Only the flag that belongs to the op class counts: overflow for 0/1, carry for 2/3
  assign carry_sel_c = funct_q[1] & alu_carry;
  assign ovf_sel_c   = ~funct_q[1] & alu_overflow;
  assign fault_c     = carry_sel_c | ovf_sel_c;

  always_comb begin
    state_d     = state_q;
    funct_d     = funct_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_ovf_d   = res_ovf_q;
    res_err_d   = res_err_q;

    if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      ST_READY: begin
        if (accept_c) begin
          funct_d = bus.cmd_funct;
          a_d     = bus.cmd_use_acc ? acc_q : bus.cmd_a;
          b_d     = bus.cmd_b;
          if (bus.cmd_funct[3]) begin
            // Illegal function: result is produced immediately, ALU is not consulted
            state_d     = ST_ERROR;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_carry_d = 1'b0;
            res_ovf_d   = 1'b0;
            res_err_d   = 1'b1;
          end else if (bus.cmd_funct[2]) begin
            state_d = ST_LOGIC;
          end else begin
            state_d = ST_ARITH;
          end
        end
      end
      ST_ARITH: begin
        res_valid_d = 1'b1;
        res_data_d  = alu_out;
        res_carry_d = carry_sel_c;
        res_ovf_d   = ovf_sel_c;
        res_err_d   = fault_c;
        if (fault_c) begin
          state_d = ST_ERROR;
        end else begin
          acc_d   = alu_out;
          state_d = ST_READY;
        end
      end
      ST_LOGIC: begin
        res_valid_d = 1'b1;
        res_data_d  = alu_out;
        res_carry_d = 1'b0;
        res_ovf_d   = 1'b0;
        res_err_d   = 1'b0;
        acc_d       = alu_out;
        state_d     = ST_READY;
      end
      ST_ERROR: begin
        if (err_clr && drain_c) begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_READY;
      funct_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct_q     <= funct_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_ovf_q   <= res_ovf_d;
      res_err_q   <= res_err_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready_c;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_carry    = res_carry_q;
  assign bus.res_overflow = res_ovf_q;
  assign bus.res_err      = res_err_q;
  assign alu_funct        = funct_q;
  assign alu_a            = a_q;
  assign alu_b            = b_q;
  assign alu_state        = state_q;
  assign acc_value        = acc_q;

`ifdef ALU_SEQ_PERF_EN
  logic                  res_load_c;
  logic [PERF_CNT_W-1:0] perf_ops_q, perf_errs_q;

  // Every result load is an issued result, including the direct illegal-funct load
  assign res_load_c = (state_q == ST_ARITH) || (state_q == ST_LOGIC) ||
                      (accept_c && bus.cmd_funct[3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops_q  <= '0;
      perf_errs_q <= '0;
    end else if (res_load_c) begin
      if (perf_ops_q != '1) begin
        perf_ops_q <= perf_ops_q + PERF_CNT_W'(1);
      end
      if (res_err_d && (perf_errs_q != '1)) begin
        perf_errs_q <= perf_errs_q + PERF_CNT_W'(1);
      end
    end
  end

  assign perf_ops  = perf_ops_q;
  assign perf_errs = perf_errs_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a behavioural ALU and
// a transaction-level reference model (accumulator, expected result per command).
module tb_alu_sequencer;
  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              err_clr;
  logic [3:0]        alu_funct;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out, acc_value;
  logic [1:0]        alu_state;
  logic              alu_carry, alu_overflow;
  logic [1:0]        noise;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0]       perf_ops, perf_errs;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] m_acc;
  int m_ops, m_errs;

  always #5 clk = ~clk;

  alu_sequencer_if #(.DATA_W(DATA_W)) bus_if ();

  alu_sequencer #(.DATA_W(DATA_W), .PERF_CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .err_clr      (err_clr),
    .alu_funct    (alu_funct),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_state    (alu_state),
    .alu_out      (alu_out),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .acc_value    (acc_value)
`ifdef ALU_SEQ_PERF_EN
    ,
    .perf_ops     (perf_ops),
    .perf_errs    (perf_errs)
`endif
  );

  // Behavioural 8-bit ALU: returns {overflow, carry, out}
  function automatic logic [9:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] o;
    logic c, v;
    s = 9'd0; o = a; c = 1'b0; v = 1'b0;
    case (f)
      4'd0, 4'd2: begin
        s = {1'b0, a} + {1'b0, b};
        o = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (o[7] != a[7]);
      end
      4'd1, 4'd3: begin
        s = {1'b0, a} - {1'b0, b};
        o = s[7:0]; c = s[8];
        v = (a[7] != b[7]) && (o[7] != a[7]);
      end
      4'd4: o = a & b;
      4'd5: o = a | b;
      4'd6: o = a ^ b;
      4'd7: o = ~a;
      default: o = a;
    endcase
    return {v, c, o};
  endfunction

  // Logic ops get random flags so the sequencer must mask them
  always @(negedge clk) noise <= 2'($urandom);

  always_comb begin
    logic [9:0] r;
    r = alu_ref(alu_funct, alu_a, alu_b);
    alu_out = r[7:0];
    if (alu_funct[2]) begin
      alu_overflow = noise[1];
      alu_carry    = noise[0];
    end else begin
      alu_overflow = r[9];
      alu_carry    = r[8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] f, input logic ua, input logic [7:0] a, input logic [7:0] b,
                        input int hold, input bit clr_while_held);
    logic [9:0] r;
    logic [7:0] opa, e_data;
    logic       e_err, e_c, e_v;
    int         waitc, lat;

    @(negedge clk);
    bus_if.cmd_valid   = 1'b1;
    bus_if.cmd_funct   = f;
    bus_if.cmd_use_acc = ua;
    bus_if.cmd_a       = a;
    bus_if.cmd_b       = b;
    waitc = 0;
    while (!bus_if.cmd_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("cmd_ready_wait", 32'(waitc < 50), 32'(1));

    opa = ua ? m_acc : a;
    if (f[3]) begin
      e_data = 8'h00; e_err = 1'b1; e_c = 1'b0; e_v = 1'b0;
    end else begin
      r = alu_ref(f, opa, b);
      e_data = r[7:0];
      if (f[2]) begin
        e_c = 1'b0; e_v = 1'b0;
      end else if (f[1]) begin
        e_c = r[8]; e_v = 1'b0;
      end else begin
        e_c = 1'b0; e_v = r[9];
      end
      e_err = e_c | e_v;
    end

    @(posedge clk);
    #1;
    bus_if.cmd_valid   = 1'b0;
    bus_if.cmd_funct   = 4'($urandom);
    bus_if.cmd_use_acc = 1'($urandom);
    bus_if.cmd_a       = 8'($urandom);
    bus_if.cmd_b       = 8'($urandom);
    check("alu_funct", 32'(alu_funct), 32'(f));
    check("alu_a", 32'(alu_a), 32'(opa));
    check("alu_b", 32'(alu_b), 32'(b));

    // Legal ops show res_valid one edge after acceptance; illegal funct loads at acceptance
    lat = 0;
    while (!bus_if.res_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), f[3] ? 32'(0) : 32'(1));
    check("res_data", 32'(bus_if.res_data), 32'(e_data));
    check("res_carry", 32'(bus_if.res_carry), 32'(e_c));
    check("res_overflow", 32'(bus_if.res_overflow), 32'(e_v));
    check("res_err", 32'(bus_if.res_err), 32'(e_err));
    check("state_after", 32'(alu_state), e_err ? 32'(3) : 32'(0));
    if (!e_err) m_acc = e_data;
    check("acc_value", 32'(acc_value), 32'(m_acc));
    m_ops++;
    if (e_err) m_errs++;
`ifdef ALU_SEQ_PERF_EN
    check("perf_ops", 32'(perf_ops), 32'(m_ops));
    check("perf_errs", 32'(perf_errs), 32'(m_errs));
`endif

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      err_clr = (clr_while_held && i == 0) ? 1'b1 : 1'b0;
      check("held_cmd_ready", 32'(bus_if.cmd_ready), 32'(0));
      @(posedge clk);
      #1;
      check("held_valid", 32'(bus_if.res_valid), 32'(1));
      check("held_data", 32'(bus_if.res_data), 32'(e_data));
      check("held_err", 32'(bus_if.res_err), 32'(e_err));
      check("held_state", 32'(alu_state), e_err ? 32'(3) : 32'(0));
    end
    err_clr = 1'b0;

    @(negedge clk);
    bus_if.res_ready = 1'b1;
    #1;
    check("ready_on_drain", 32'(bus_if.cmd_ready), 32'(!e_err));
    @(posedge clk);
    #1;
    bus_if.res_ready = 1'b0;
    check("res_valid_clear", 32'(bus_if.res_valid), 32'(0));

    if (e_err) begin
      check("error_blocks_cmd", 32'(bus_if.cmd_ready), 32'(0));
      @(negedge clk);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      check("err_clr_exit", 32'(alu_state), 32'(0));
      check("ready_after_clr", 32'(bus_if.cmd_ready), 32'(1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] f;
    int         h;
    rst_n              = 1'b0;
    err_clr            = 1'b0;
    bus_if.cmd_valid   = 1'b0;
    bus_if.cmd_funct   = 4'd0;
    bus_if.cmd_use_acc = 1'b0;
    bus_if.cmd_a       = 8'd0;
    bus_if.cmd_b       = 8'd0;
    bus_if.res_ready   = 1'b0;
    m_acc = 8'd0; m_ops = 0; m_errs = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'(0));
    check("rst_state", 32'(alu_state), 32'(0));
    check("rst_res_valid", 32'(bus_if.res_valid), 32'(0));
    check("rst_acc", 32'(acc_value), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // add 0x12 + 0x34
    run_op(4'd0, 1'b0, 8'h12, 8'h34, 0, 1'b0);

    // reset while the op is in ARITH
    @(negedge clk);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_funct = 4'd0;
    bus_if.cmd_a     = 8'h01;
    bus_if.cmd_b     = 8'h01;
    @(posedge clk);
    #1;
    bus_if.cmd_valid = 1'b0;
    check("mid_arith_state", 32'(alu_state), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(alu_state), 32'(0));
    check("midrst_funct", 32'(alu_funct), 32'(0));
    check("midrst_a", 32'(alu_a), 32'(0));
    check("midrst_b", 32'(alu_b), 32'(0));
    check("midrst_acc", 32'(acc_value), 32'(0));
    check("midrst_res", 32'({bus_if.res_valid, bus_if.res_data, bus_if.res_carry,
                             bus_if.res_overflow, bus_if.res_err}), 32'(0));
    check("midrst_cmd_ready", 32'(bus_if.cmd_ready), 32'(0));
    m_acc = 8'd0; m_ops = 0; m_errs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("post_rst_no_result", 32'(bus_if.res_valid), 32'(0));
    end

    // signed overflow, err_clr while result is held is ignored
    run_op(4'd0, 1'b0, 8'h70, 8'h20, 3, 1'b1);
    // accumulator chain: acc=0x0F then AND with 0x3C
    run_op(4'd5, 1'b0, 8'h0F, 8'h00, 0, 1'b0);
    run_op(4'd4, 1'b1, 8'hFF, 8'h3C, 0, 1'b0);
    // backpressure for five cycles
    run_op(4'd0, 1'b0, 8'h01, 8'h02, 5, 1'b0);
    // illegal funct
    run_op(4'd9, 1'b0, 8'h55, 8'hAA, 1, 1'b0);
    // carry fault on funct 2
    run_op(4'd2, 1'b0, 8'hF0, 8'h20, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      f = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      h = $urandom_range(0, 3);
      run_op(f, 1'($urandom), 8'($urandom), 8'($urandom), h, (h > 0) ? 1'($urandom) : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
